// File: rtl/piezo_pkg.sv
// Shared definitions for the piezo note sequencer: note codes, base-octave
// frequency table, half-period helper and FSM state type.
package piezo_pkg;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_C    = 4'd1;
    localparam logic [3:0] NOTE_CS   = 4'd2;
    localparam logic [3:0] NOTE_D    = 4'd3;
    localparam logic [3:0] NOTE_DS   = 4'd4;
    localparam logic [3:0] NOTE_E    = 4'd5;
    localparam logic [3:0] NOTE_F    = 4'd6;
    localparam logic [3:0] NOTE_FS   = 4'd7;
    localparam logic [3:0] NOTE_G    = 4'd8;
    localparam logic [3:0] NOTE_GS   = 4'd9;
    localparam logic [3:0] NOTE_A    = 4'd10;
    localparam logic [3:0] NOTE_AS   = 4'd11;
    localparam logic [3:0] NOTE_B    = 4'd12;

    // Octave 4 frequencies in Hz, indexed by note code
    localparam int unsigned NOTE_HZ [1:12] = '{262, 277, 294, 311, 330, 349,
                                               370, 392, 415, 440, 466, 494};

    typedef enum logic [1:0] {IDLE, LOAD, TONE, GAP} state_e;

    // Clocks per half cycle of the base-octave note; 0 marks a rest code
    function automatic int unsigned half_period(input int unsigned frq, input logic [3:0] code);
        if (code >= NOTE_C && code <= NOTE_B)
            return frq / (2 * NOTE_HZ[code]);
        return 0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with flush; pointers carry an extra MSB so that
// full and empty are distinguishable without a separate counter.
module sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty   = (wr_q == rd_q);
    assign count   = wr_q - rd_q;
    assign rd_data = mem_q[rd_q[AW-1:0]];

    // A push into a full FIFO is lost even when a pop frees a slot this cycle
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_d = wr_q + (AW+1)'(do_push);
        rd_d = rd_q + (AW+1)'(do_pop);
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/piezo_tone_seq.sv
// Queued piezo note sequencer: plays FIFO'd notes as square waves for a
// programmable number of ticks, each followed by a fixed silent gap.
module piezo_tone_seq
    import piezo_pkg::*;
#(
    parameter int unsigned FRQ     = 1_000_000,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DUR_W   = 4,
    parameter int unsigned TICK_MS = 50,
    parameter int unsigned GAP_MS  = 10
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [3:0]       note_code,
    input  logic [1:0]       note_oct,
    input  logic [DUR_W-1:0] note_dur,
    input  logic             flush,
    output logic             piezo_wire,
    output logic             busy,
    output logic [3:0]       cur_note
);

    localparam int unsigned TICK_CNT = FRQ / 1000 * TICK_MS;
    localparam int unsigned GAP_CNT  = FRQ / 1000 * GAP_MS;
    localparam int          TICK_W   = $clog2(TICK_CNT + 1);
    localparam int          GAP_W    = $clog2(GAP_CNT + 1);
    localparam int          HALF_W   = $clog2(half_period(FRQ, NOTE_C) + 1);
    localparam int          ENTRY_W  = 4 + 2 + DUR_W;
    localparam int          CNT_W    = $clog2(DEPTH) + 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CNT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CNT - 1);

    state_e              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [HALF_W-1:0]   phase_q, phase_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic                rest_q, rest_d;
    logic [3:0]          code_q, code_d;
    logic                wire_q, wire_d;

    logic                pop;
    logic                fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_cnt;
    logic [ENTRY_W-1:0]  head;
    logic [3:0]          head_code;
    logic [1:0]          head_oct;
    logic [DUR_W-1:0]    head_dur;
    logic [HALF_W-1:0]   half_tab [16];

    // Constant half-period per code, folded at elaboration so no divider is built
    for (genvar k = 0; k < 16; k++) begin : g_half
        assign half_tab[k] = HALF_W'(half_period(FRQ, 4'(k)));
    end

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .flush   (flush),
        .push    (note_valid),
        .pop     (pop),
        .wr_data ({note_code, note_oct, note_dur}),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    assign head_code = head[ENTRY_W-1 -: 4];
    assign head_oct  = head[DUR_W+1 -: 2];
    assign head_dur  = head[DUR_W-1:0];

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        dur_d   = dur_q;
        gap_d   = gap_q;
        phase_d = phase_q;
        half_d  = half_q;
        rest_d  = rest_q;
        code_d  = code_q;
        wire_d  = wire_q;
        pop     = 1'b0;
        if (flush) begin
            state_d = IDLE;
            tick_d  = '0;
            dur_d   = '0;
            gap_d   = '0;
            phase_d = '0;
            wire_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (!fifo_empty) state_d = LOAD;
                LOAD: begin
                    pop    = 1'b1;
                    code_d = head_code;
                    if (head_dur == '0) begin
                        state_d = (fifo_cnt > CNT_W'(1)) ? LOAD : IDLE;
                    end else begin
                        half_d  = half_tab[head_code] >> head_oct;
                        rest_d  = (half_tab[head_code] == '0);
                        dur_d   = head_dur;
                        tick_d  = '0;
                        phase_d = '0;
                        wire_d  = 1'b0;
                        state_d = TONE;
                    end
                end
                TONE: begin
                    if (!rest_q) begin
                        if (phase_q == half_q - 1'b1) begin
                            phase_d = '0;
                            wire_d  = !wire_q;
                        end else begin
                            phase_d = phase_q + 1'b1;
                        end
                    end
                    // Each tick consumes one duration unit; the last one ends the note
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (dur_q == DUR_W'(1)) begin
                            wire_d  = 1'b0;
                            gap_d   = '0;
                            state_d = GAP;
                        end else begin
                            dur_d = dur_q - 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        state_d = fifo_empty ? IDLE : LOAD;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            dur_q   <= '0;
            gap_q   <= '0;
            phase_q <= '0;
            half_q  <= '0;
            rest_q  <= 1'b0;
            code_q  <= '0;
            wire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
            phase_q <= phase_d;
            half_q  <= half_d;
            rest_q  <= rest_d;
            code_q  <= code_d;
            wire_q  <= wire_d;
        end
    end

    assign piezo_wire = wire_q;
    assign cur_note   = (state_q == TONE) ? code_q : 4'd0;
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign note_ready = !fifo_full;

endmodule

// File: tb/tb_piezo_tone_seq.sv
// Bench for piezo_tone_seq: directed scenarios plus random note bursts, every
// cycle compared against a timestamp-based model of the note schedule.
module tb_piezo_tone_seq;

    localparam int unsigned FRQ   = 1_000_000;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DUR_W = 4;
    localparam longint      TICK  = 1000;
    localparam longint      GAPC  = 1000;

    typedef struct packed {
        logic [3:0]       c;
        logic [1:0]       o;
        logic [DUR_W-1:0] d;
    } note_t;

    logic             clk = 1'b0;
    logic             nrst;
    logic             note_valid;
    logic             note_ready;
    logic [3:0]       note_code;
    logic [1:0]       note_oct;
    logic [DUR_W-1:0] note_dur;
    logic             flush;
    logic             piezo_wire;
    logic             busy;
    logic [3:0]       cur_note;

    int checks = 0;
    int errors = 0;

    piezo_tone_seq #(
        .FRQ(FRQ), .DEPTH(DEPTH), .DUR_W(DUR_W), .TICK_MS(1), .GAP_MS(1)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_code  (note_code),
        .note_oct   (note_oct),
        .note_dur   (note_dur),
        .flush      (flush),
        .piezo_wire (piezo_wire),
        .busy       (busy),
        .cur_note   (cur_note)
    );

    always #5 clk = ~clk;

    // Schedule model: absolute edge numbers of the next pop, tone window and gap end
    note_t  q[$];
    longint n      = 0;
    bit     m_act  = 0;
    longint m_load = -1;
    longint m_ts   = -1;
    longint m_te   = -1;
    longint m_ge   = -1;
    longint m_half = 0;
    int     m_code = 0;

    function automatic longint note_half(input int c, input int o);
        int unsigned hz [12] = '{262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494};
        if (c >= 1 && c <= 12) return longint'((FRQ / (2 * hz[c-1])) >> o);
        return 0;
    endfunction

    task automatic model_edge();
        int    cnt;
        note_t h;
        note_t nw;
        n++;
        cnt = q.size();
        if (!nrst || flush) begin
            q.delete();
            m_act  = 0;
            m_load = -1;
            m_ts   = -1;
            m_te   = -1;
            m_ge   = -1;
            return;
        end
        if (!m_act) begin
            if (cnt > 0) begin
                m_act  = 1;
                m_load = n + 1;
            end
        end else if (n == m_load) begin
            h      = q.pop_front();
            m_load = -1;
            if (h.d == 0) begin
                if (cnt > 1) m_load = n + 1;
                else         m_act  = 0;
            end else begin
                m_ts   = n;
                m_te   = n + longint'(h.d) * TICK;
                m_ge   = m_te + GAPC;
                m_code = int'(h.c);
                m_half = note_half(int'(h.c), int'(h.o));
            end
        end else if (n == m_ge) begin
            m_ge = -1;
            if (cnt > 0) m_load = n + 1;
            else         m_act  = 0;
        end
        if (note_valid && cnt < int'(DEPTH)) begin
            nw.c = note_code;
            nw.o = note_oct;
            nw.d = note_dur;
            q.push_back(nw);
        end
    endtask

    function automatic bit in_tone();
        return (m_ts >= 0) && (n >= m_ts) && (n < m_te);
    endfunction

    task automatic check_outputs();
        logic       ew;
        logic [3:0] ec;
        logic       eb;
        logic       er;
        ew = (in_tone() && m_half > 0) ? logic'(((n - m_ts) / m_half) % 2) : 1'b0;
        ec = in_tone() ? 4'(m_code) : 4'd0;
        eb = m_act || (q.size() > 0);
        er = (q.size() < int'(DEPTH));
        checks++;
        assert (piezo_wire === ew) else begin
            errors++;
            $error("FAIL piezo_wire cyc=%0d got=%b exp=%b", n, piezo_wire, ew);
        end
        checks++;
        assert (cur_note === ec) else begin
            errors++;
            $error("FAIL cur_note cyc=%0d got=%0d exp=%0d", n, cur_note, ec);
        end
        checks++;
        assert (busy === eb) else begin
            errors++;
            $error("FAIL busy cyc=%0d got=%b exp=%b", n, busy, eb);
        end
        checks++;
        assert (note_ready === er) else begin
            errors++;
            $error("FAIL note_ready cyc=%0d got=%b exp=%b", n, note_ready, er);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_note(input int c, input int o, input int d);
        note_valid = 1'b1;
        note_code  = 4'(c);
        note_oct   = 2'(o);
        note_dur   = DUR_W'(d);
    endtask

    task automatic push_one(input int c, input int o, input int d);
        set_note(c, o, d);
        step();
        note_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget; i++) begin
            if (!m_act && q.size() == 0) begin
                done = 1;
                break;
            end
            step();
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL %s timeout got=busy exp=idle within %0d cycles", tag, budget);
        end
        step();
        step();
    endtask

    task automatic wait_until(input string tag, input longint target, input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget; i++) begin
            if (n >= target) begin
                done = 1;
                break;
            end
            step();
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL %s timeout got=cyc %0d exp=cyc %0d", tag, n, target);
        end
    endtask

    initial begin
        nrst       = 1'b0;
        note_valid = 1'b0;
        note_code  = '0;
        note_oct   = '0;
        note_dur   = '0;
        flush      = 1'b0;

        // Reset state
        step();
        step();
        nrst = 1'b1;
        step();

        // A4 for two ticks, then A5 for one
        push_one(10, 0, 2);
        wait_idle("a4", 6000);
        push_one(10, 1, 1);
        wait_idle("a5", 4000);

        // Rest, C4, out-of-range rest code back to back
        push_one(0, 0, 1);
        push_one(1, 0, 1);
        push_one(14, 0, 1);
        wait_idle("rests", 12000);

        // note_valid held for six notes while the first one starts
        for (int i = 0; i < 6; i++) begin
            set_note($urandom_range(1, 12), $urandom_range(0, 3), 1);
            step();
        end
        note_valid = 1'b0;
        wait_idle("fill", 16000);

        // Zero-duration entry is skipped without a gap
        push_one(3, 0, 0);
        push_one(5, 0, 1);
        wait_idle("skip", 4000);

        // Flush mid-tone with a concurrent push
        push_one(10, 0, 3);
        wait_until("to_tone", m_ts + 1500, 4000);
        set_note(7, 0, 1);
        flush = 1'b1;
        step();
        flush      = 1'b0;
        note_valid = 1'b0;
        step();
        step();

        // Reset in the middle of a gap
        push_one(1, 0, 1);
        wait_until("to_gap", n + 2 + TICK + 500, 4000);
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        step();
        step();

        // Random bursts, arriving idle or while playing
        for (int r = 0; r < 8; r++) begin
            int gap_cycles;
            int burst;
            gap_cycles = $urandom_range(0, 300);
            for (int i = 0; i < gap_cycles; i++) step();
            burst = $urandom_range(1, 2);
            for (int b = 0; b < burst; b++) begin
                set_note($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1));
                step();
            end
            note_valid = 1'b0;
        end
        wait_idle("random", 40000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
